cmd_line_parser: RTL and testbench
==================================

CMD_LINE_PARSER -- requirements
Module: cmd_line_parser

Interface
REQ-001 Parameter LINE_LEN, default 32: maximum stored characters per line.
REQ-002 clk_48mhz  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_data  input  8  received byte from the USB UART output stream.
REQ-005 rx_valid  input  1  rx_data is valid.
REQ-006 rx_ready  output  1  parser accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both 1.
REQ-007 cmd_code  output  3  decoded command; stable while cmd_valid is 1.
REQ-008 cmd_valid  output  1  command available.
REQ-009 cmd_ready  input  1  consumer takes the command; transfer occurs when cmd_valid and cmd_ready are both 1.
REQ-010 line_data  output  8*LINE_LEN  stored line; first character in bits [7:0]; unused bytes are 0x00.
REQ-011 line_len  output  6  number of valid characters in line_data, range 0..LINE_LEN.

Function
REQ-012 The parser SHALL use three states: COLLECT, DECODE and HOLD. rx_ready SHALL be 1 only in COLLECT and SHALL be 0 while reset is asserted.
REQ-013 In COLLECT, an accepted byte 0x0D (CR) SHALL cause a transition to DECODE on the next edge.
REQ-014 In COLLECT, an accepted byte 0x0A (LF) SHALL be discarded with no state change.
REQ-015 In COLLECT, an accepted byte 0x08 or 0x7F SHALL do the following: decrement line_len and zero the vacated byte when line_len > 0; do nothing when line_len = 0.
REQ-016 In COLLECT, an accepted byte 0x41-0x5A SHALL be stored as its lowercase equivalent (+0x20). Any other byte SHALL be stored unchanged at index line_len, and line_len SHALL increment.
REQ-017 When line_len = LINE_LEN, an accepted storable byte SHALL be dropped and SHALL set a sticky internal overflow flag. The flag SHALL clear only when the line completes.
REQ-018 DECODE SHALL last exactly one cycle and SHALL compare line_data/line_len against the package keywords:
  - "start" -> 1
  - "write" -> 2
  - "read" -> 3
  - "clear" -> 4
  - any other non-empty line -> 7 (UNKNOWN)
  - overflow flag set -> 6 (OVERFLOW), taking priority over all matches
REQ-019 If line_len = 0 and overflow is clear, DECODE SHALL return to COLLECT with no command emitted.
REQ-020 Otherwise DECODE SHALL move to HOLD with cmd_code registered. cmd_valid SHALL be 1 in the first HOLD cycle, which is two edges after the edge that accepted the CR.
REQ-021 In HOLD, cmd_valid, cmd_code, line_data and line_len SHALL stay stable until cmd_ready = 1.
REQ-022 On the cmd_ready handshake edge, the parser SHALL do all of the following together: clear line_data to 0, set line_len to 0, clear overflow, deassert cmd_valid, and return to COLLECT.
REQ-023 Bytes offered during DECODE or HOLD SHALL NOT be accepted and SHALL NOT be lost, because the upstream stream holds them under rx_ready = 0.
REQ-024 cmd_ready asserted while cmd_valid = 0 SHALL have no effect.
REQ-025 A line of exactly LINE_LEN characters followed by CR SHALL NOT set overflow.

Reset
REQ-026 On reset assertion, the parser SHALL immediately force: state COLLECT, line_data 0, line_len 0, overflow 0, cmd_valid 0, cmd_code 0, rx_ready 0.
REQ-027 Reset asserted mid-line or in HOLD SHALL abandon the line and any pending command without emitting it.
REQ-028 rx_ready SHALL become 1 in the first cycle after reset deasserts.

Structure
REQ-029 A shared package SHALL hold:
  - the cmd_code constants (NONE=0, START=1, WRITE=2, READ=3, CLEAR=4, OVERFLOW=6, UNKNOWN=7);
  - the keyword byte constants, stored first character in the lowest byte;
  - the control-byte constants CR, LF, BS and DEL;
  - the state encoding.
REQ-030 Keyword comparison SHALL live in one combinational sub-module, keyword_match. Its inputs SHALL be line_data and line_len, and its output SHALL be cmd_code.

Verification
REQ-031 Send "start",CR with cmd_ready=1 -> cmd_valid high for 1 cycle, two edges after CR, cmd_code=1, line_len=5, line_data[39:0]="trats" (byte order).
REQ-032 Send "WRITX",BS,"e",CR -> cmd_code=2 and line_len=5.
REQ-033 Send 40 × "a" then CR -> cmd_code=6 and line_len=32. Then send 32 × "a" then CR -> cmd_code=7 with no overflow.
REQ-034 Send CR,LF,CR -> no cmd_valid pulse; rx_ready stays 1 throughout.
REQ-035 Send "read",CR with cmd_ready=0 for 10 cycles while upstream holds "x" valid -> cmd_code=3 held stable and rx_ready=0; after the handshake, "x" is accepted as line_len=1.
REQ-036 Assert reset after "cle" -> line_len=0 and rx_ready=0 asynchronously. After release, "clear",CR -> cmd_code=4.

Source files
------------

// File: rtl/cmd_line_parser_pkg.sv
// cmd_line_parser_pkg: command codes, keyword bytes,
// control characters and parser state encoding.
package cmd_line_parser_pkg;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_START    = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ     = 3'd3,
    CMD_CLEAR    = 3'd4,
    CMD_OVERFLOW = 3'd6,
    CMD_UNKNOWN  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DECODE  = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;

  // First keyword character sits in the lowest byte.
  localparam logic [39:0] KW_START = 40'h74_72_61_74_73;
  localparam logic [39:0] KW_WRITE = 40'h65_74_69_72_77;
  localparam logic [31:0] KW_READ  = 32'h64_61_65_72;
  localparam logic [39:0] KW_CLEAR = 40'h72_61_65_6C_63;

  function automatic logic [7:0] to_lower(
    input logic [7:0] b
  );
    if (b >= 8'h41 && b <= 8'h5A)
      return b + 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/cmd_line_parser_keyword_match.sv
// keyword_match: combinational keyword lookup.
// In: line_data, line_len. Out: cmd_code.
module keyword_match
  import cmd_line_parser_pkg::*;
#(
  parameter int LINE_LEN = 32
) (
  input  logic [8*LINE_LEN-1:0] line_data,
  input  logic [5:0]            line_len,
  output logic [2:0]            cmd_code
);

  logic w_len4;
  logic w_len5;
  logic w_start;
  logic w_write;
  logic w_read;
  logic w_clear;
  logic w_empty;

  // Bytes past line_len are always zero, so
  // the length check plus a low-byte compare is exact.
  assign w_len4  = (line_len == 6'd4);
  assign w_len5  = (line_len == 6'd5);
  assign w_empty = (line_len == 6'd0);
  assign w_start = w_len5 && (line_data[39:0] == KW_START);
  assign w_write = w_len5 && (line_data[39:0] == KW_WRITE);
  assign w_clear = w_len5 && (line_data[39:0] == KW_CLEAR);
  assign w_read  = w_len4 && (line_data[31:0] == KW_READ);

  always_comb begin
    cmd_code = CMD_UNKNOWN;
    unique case (1'b1)
      w_empty: cmd_code = CMD_NONE;
      w_start: cmd_code = CMD_START;
      w_write: cmd_code = CMD_WRITE;
      w_read:  cmd_code = CMD_READ;
      w_clear: cmd_code = CMD_CLEAR;
      default: cmd_code = CMD_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/cmd_line_parser.sv
// cmd_line_parser: collects a text line from a byte
// stream and emits a decoded command on CR.
// Ports: clk_48mhz, reset (async high); rx_* byte
// stream in; cmd_* command out; line_data/line_len.
module cmd_line_parser
  import cmd_line_parser_pkg::*;
#(
  parameter int LINE_LEN = 32
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [2:0]            cmd_code,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [8*LINE_LEN-1:0] line_data,
  output logic [5:0]            line_len
);

  localparam int IDXW = $clog2(8 * LINE_LEN);
  localparam logic [5:0] MAXLEN = 6'(LINE_LEN);

  state_e                r_state;
  logic [8*LINE_LEN-1:0] r_line;
  logic [5:0]            r_len;
  logic                  r_ovf;
  logic                  r_valid;
  logic [2:0]            r_code;

  state_e                w_state_nxt;
  logic [8*LINE_LEN-1:0] w_line_nxt;
  logic [5:0]            w_len_nxt;
  logic                  w_ovf_nxt;
  logic                  w_valid_nxt;
  logic [2:0]            w_code_nxt;

  logic            w_accept;
  logic            w_is_cr;
  logic            w_is_lf;
  logic            w_is_bs;
  logic            w_full;
  logic [5:0]      w_len_m1;
  logic [IDXW-1:0] w_wr_idx;
  logic [IDXW-1:0] w_bs_idx;
  logic [2:0]      w_match;

  keyword_match #(
    .LINE_LEN (LINE_LEN)
  ) u_match (
    .line_data (r_line),
    .line_len  (r_len),
    .cmd_code  (w_match)
  );

  // Gate with reset so ready drops the instant
  // reset is asserted, not at the next edge.
  assign rx_ready = (r_state == ST_COLLECT) && !reset;
  assign w_accept = rx_valid && rx_ready;

  assign w_is_cr  = (rx_data == CH_CR);
  assign w_is_lf  = (rx_data == CH_LF);
  assign w_is_bs  = (rx_data == CH_BS) ||
                    (rx_data == CH_DEL);
  assign w_full   = (r_len == MAXLEN);
  assign w_len_m1 = r_len - 6'd1;
  // Truncation only matters when full, where the
  // write index is never used.
  assign w_wr_idx = IDXW'({r_len, 3'b000});
  assign w_bs_idx = IDXW'({w_len_m1, 3'b000});

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_ovf;
    w_valid_nxt = r_valid;
    w_code_nxt  = r_code;
    unique case (r_state)
      ST_COLLECT: begin
        if (w_accept) begin
          if (w_is_cr) begin
            w_state_nxt = ST_DECODE;
          end else if (w_is_lf) begin
            w_state_nxt = ST_COLLECT;
          end else if (w_is_bs) begin
            if (r_len != 6'd0) begin
              w_len_nxt = w_len_m1;
              w_line_nxt[w_bs_idx +: 8] = 8'h00;
            end
          end else if (w_full) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_line_nxt[w_wr_idx +: 8] =
              to_lower(rx_data);
            w_len_nxt = r_len + 6'd1;
          end
        end
      end
      ST_DECODE: begin
        if (r_len == 6'd0 && !r_ovf) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_HOLD;
          w_valid_nxt = 1'b1;
          w_code_nxt  = r_ovf ? CMD_OVERFLOW
                              : w_match;
        end
      end
      ST_HOLD: begin
        if (cmd_ready) begin
          w_state_nxt = ST_COLLECT;
          w_line_nxt  = '0;
          w_len_nxt   = 6'd0;
          w_ovf_nxt   = 1'b0;
          w_valid_nxt = 1'b0;
          w_code_nxt  = CMD_NONE;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_state <= ST_COLLECT;
      r_line  <= '0;
      r_len   <= 6'd0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_code  <= CMD_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_len   <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= w_valid_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign cmd_code  = r_code;
  assign cmd_valid = r_valid;
  assign line_data = r_line;
  assign line_len  = r_len;

endmodule

// File: tb/tb_cmd_line_parser.sv
// tb_cmd_line_parser: directed self-checking bench
// for cmd_line_parser with immediate assertions.
module tb_cmd_line_parser;

  logic         clk_48mhz;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [2:0]   cmd_code;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] line_data;
  logic [5:0]   line_len;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [255:0] L_START = 256'h7472617473;
  localparam logic [255:0] L_WRITE = 256'h6574697277;
  localparam logic [255:0] L_READ  = 256'h64616572;
  localparam logic [255:0] L_CLEAR = 256'h7261656C63;
  localparam logic [255:0] L_AAAA  = {32{8'h61}};

  cmd_line_parser #(.LINE_LEN(32)) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cmd_code  (cmd_code),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .line_data (line_data),
    .line_len  (line_len)
  );

  initial begin
    clk_48mhz = 1'b0;
    forever #5 clk_48mhz = ~clk_48mhz;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk("send_ready", rx_ready, 1);
    @(posedge clk_48mhz);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send(s[i]);
  endtask

  // Call right after the CR was accepted,
  // with cmd_ready = 1.
  task automatic expect_cmd(
    input string        tag,
    input logic [2:0]   code,
    input logic [5:0]   len,
    input logic [255:0] data
  );
    chk({tag, "_decode_valid"}, cmd_valid, 0);
    @(posedge clk_48mhz);
    #1;
    chk({tag, "_valid"}, cmd_valid, 1);
    chk({tag, "_code"}, cmd_code, code);
    chk({tag, "_len"}, line_len, len);
    chk({tag, "_data"}, line_data, data);
    @(posedge clk_48mhz);
    #1;
    chk({tag, "_done_valid"}, cmd_valid, 0);
    chk({tag, "_done_len"}, line_len, 0);
    chk({tag, "_done_data"}, line_data, 0);
    chk({tag, "_done_ready"}, rx_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b1;
    #1;
    chk("rst_ready", rx_ready, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_code", cmd_code, 0);
    chk("rst_len", line_len, 0);
    chk("rst_data", line_data, 0);
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    reset = 1'b0;
    #1;
    chk("rel_ready", rx_ready, 1);

    send_str("start");
    send(8'h0D);
    expect_cmd("start", 3'd1, 6'd5, L_START);

    send_str("WRITX");
    send(8'h08);
    chk("bs_len", line_len, 4);
    chk("bs_data", line_data, 256'h74697277);
    send(8'h65);
    send(8'h0D);
    expect_cmd("write", 3'd2, 6'd5, L_WRITE);

    repeat (40) send(8'h61);
    chk("ovf_len", line_len, 32);
    send(8'h0D);
    expect_cmd("ovf", 3'd6, 6'd32, L_AAAA);
    repeat (32) send(8'h61);
    send(8'h0D);
    expect_cmd("full", 3'd7, 6'd32, L_AAAA);

    send(8'h7F);
    chk("del_empty_len", line_len, 0);
    send(8'h51);
    chk("upper_q", line_data, 256'h71);
    send(8'h7F);
    chk("del_len", line_len, 0);
    chk("del_data", line_data, 0);

    send(8'h0D);
    chk("cr1_decode_ready", rx_ready, 0);
    @(posedge clk_48mhz);
    #1;
    chk("cr1_ready", rx_ready, 1);
    chk("cr1_valid", cmd_valid, 0);
    send(8'h0A);
    chk("lf_ready", rx_ready, 1);
    chk("lf_len", line_len, 0);
    send(8'h0D);
    @(posedge clk_48mhz);
    #1;
    chk("cr2_ready", rx_ready, 1);
    chk("cr2_valid", cmd_valid, 0);

    cmd_ready = 1'b0;
    send_str("read");
    send(8'h0D);
    rx_data  = 8'h78;
    rx_valid = 1'b1;
    @(posedge clk_48mhz);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", cmd_valid, 1);
      chk("hold_code", cmd_code, 3);
      chk("hold_len", line_len, 4);
      chk("hold_data", line_data, L_READ);
      chk("hold_ready", rx_ready, 0);
      @(posedge clk_48mhz);
      #1;
    end
    cmd_ready = 1'b1;
    @(posedge clk_48mhz);
    #1;
    chk("hs_valid", cmd_valid, 0);
    chk("hs_len", line_len, 0);
    chk("hs_ready", rx_ready, 1);
    @(posedge clk_48mhz);
    #1;
    rx_valid = 1'b0;
    chk("x_len", line_len, 1);
    chk("x_data", line_data, 256'h78);
    send(8'h08);
    chk("x_bs_len", line_len, 0);

    cmd_ready = 1'b0;
    send_str("start");
    send(8'h0D);
    @(posedge clk_48mhz);
    #1;
    chk("hrst_pre_valid", cmd_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("hrst_valid", cmd_valid, 0);
    chk("hrst_code", cmd_code, 0);
    chk("hrst_len", line_len, 0);
    chk("hrst_ready", rx_ready, 0);
    @(negedge clk_48mhz);
    reset = 1'b0;
    cmd_ready = 1'b1;
    repeat (2) @(posedge clk_48mhz);
    #1;
    chk("hrst_after_valid", cmd_valid, 0);
    chk("hrst_after_ready", rx_ready, 1);

    send_str("cle");
    chk("cle_len", line_len, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_len", line_len, 0);
    chk("mrst_data", line_data, 0);
    chk("mrst_ready", rx_ready, 0);
    repeat (2) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    reset = 1'b0;
    #1;
    chk("mrst_rel_ready", rx_ready, 1);
    send_str("clear");
    send(8'h0D);
    expect_cmd("clear", 3'd4, 6'd5, L_CLEAR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
